// File: rtl/port_out_uart_tx_pkg.sv
// Shared definitions for the PortOut UART transmitter: FSM state encoding and frame constants.
package port_out_uart_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

endpackage

// File: rtl/port_out_uart_tx_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with registered full/empty/count flags.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count_next;
  logic             do_push;
  logic             do_pop;

  // A push against a full FIFO is ignored even if a pop happens in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_comb begin
    count_next = count;
    if (do_push && !do_pop) begin
      count_next = count + 1'b1;
    end else if (do_pop && !do_push) begin
      count_next = count - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      full  <= (count_next == (AW+1)'(DEPTH));
      empty <= (count_next == '0);
    end
  end

  // Storage needs no reset: a flushed FIFO never exposes stale entries.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/port_out_uart_tx.sv
// Buffers bytes stored to the PortOut address and serializes them as back-to-back 8N1 UART frames.
module port_out_uart_tx
  import port_out_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 8,
  parameter int ADDR_W       = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              WriteEnable,
  input  logic [7:0]        WriteData,
  input  logic              ClearOverflow,
  output logic              Tx,
  output logic              Busy,
  output logic              Full,
  output logic              Empty,
  output logic [ADDR_W:0]   Count,
  output logic              Overflow
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);

  uart_state_t       state;
  uart_state_t       state_next;
  logic [BAUD_W-1:0] baud_cnt;
  logic [BAUD_W-1:0] baud_next;
  logic [2:0]        bit_idx;
  logic [2:0]        bit_next;
  logic [7:0]        shift_reg;
  logic [7:0]        shift_next;
  logic [7:0]        fifo_dout;
  logic              tx_next;
  logic              pop;
  logic              baud_done;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (WriteEnable),
    .pop   (pop),
    .din   (WriteData),
    .dout  (fifo_dout),
    .full  (Full),
    .empty (Empty),
    .count (Count)
  );

  assign baud_done = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));

  // Tx is computed one cycle ahead so the line itself comes straight from a flop.
  always_comb begin
    state_next = state;
    baud_next  = baud_cnt;
    bit_next   = bit_idx;
    shift_next = shift_reg;
    tx_next    = Tx;
    pop        = 1'b0;
    if (state != IDLE) begin
      baud_next = baud_done ? '0 : baud_cnt + 1'b1;
    end
    case (state)
      IDLE: begin
        tx_next = 1'b1;
        if (!Empty) begin
          pop        = 1'b1;
          shift_next = fifo_dout;
          tx_next    = 1'b0;
          baud_next  = '0;
          state_next = START;
        end
      end
      START: begin
        if (baud_done) begin
          tx_next    = shift_reg[0];
          bit_next   = '0;
          state_next = DATA;
        end
      end
      DATA: begin
        if (baud_done) begin
          if (bit_idx == 3'(DATA_BITS - 1)) begin
            tx_next    = 1'b1;
            bit_next   = '0;
            state_next = STOP;
          end else begin
            bit_next   = bit_idx + 1'b1;
            shift_next = shift_reg >> 1;
            tx_next    = shift_reg[1];
          end
        end
      end
      STOP: begin
        if (baud_done) begin
          if (bit_idx == 3'(STOP_BITS - 1)) begin
            bit_next = '0;
            if (!Empty) begin
              pop        = 1'b1;
              shift_next = fifo_dout;
              tx_next    = 1'b0;
              state_next = START;
            end else begin
              state_next = IDLE;
            end
          end else begin
            bit_next = bit_idx + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      Tx        <= 1'b1;
      Busy      <= 1'b0;
    end else begin
      state     <= state_next;
      baud_cnt  <= baud_next;
      bit_idx   <= bit_next;
      shift_reg <= shift_next;
      Tx        <= tx_next;
      Busy      <= (state_next != IDLE);
    end
  end

  // A dropped write wins over a simultaneous clear so no loss goes unreported.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Overflow <= 1'b0;
    end else if (WriteEnable && Full) begin
      Overflow <= 1'b1;
    end else if (ClearOverflow) begin
      Overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_port_out_uart_tx.sv
// Bench for port_out_uart_tx: frame-timing reference model, line decoder and directed/random stimulus.
module tb_port_out_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       WriteEnable;
  logic [7:0] WriteData;
  logic       ClearOverflow;
  logic       Tx;
  logic       Busy;
  logic       Full;
  logic       Empty;
  logic [2:0] Count;
  logic       Overflow;

  int checks = 0;
  int errors = 0;
  int busy_cycles = 0;
  bit cmp_en = 0;

  port_out_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH),
    .ADDR_W       (2)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .WriteEnable   (WriteEnable),
    .WriteData     (WriteData),
    .ClearOverflow (ClearOverflow),
    .Tx            (Tx),
    .Busy          (Busy),
    .Full          (Full),
    .Empty         (Empty),
    .Count         (Count),
    .Overflow      (Overflow)
  );

  always #5 clk = ~clk;

  // Reference: a byte queue plus "cycles since this frame started"; the line level is read from t.
  logic [7:0] mq[$];
  logic [7:0] sent_q[$];
  logic [7:0] m_byte = 8'h00;
  bit         m_active = 0;
  int         m_t = 0;
  bit         m_ovf = 0;
  bit         full_pre;
  bit         empty_pre;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mq.delete();
      m_active = 0;
      m_t = 0;
      m_ovf = 0;
    end else begin
      full_pre  = (mq.size() == DEPTH);
      empty_pre = (mq.size() == 0);
      if (m_active) begin
        m_t++;
        if (m_t == 10 * CPB) begin
          if (!empty_pre) begin
            m_byte = mq.pop_front();
            sent_q.push_back(m_byte);
            m_t = 0;
          end else begin
            m_active = 0;
          end
        end
      end else if (!empty_pre) begin
        m_byte = mq.pop_front();
        sent_q.push_back(m_byte);
        m_active = 1;
        m_t = 0;
      end
      if (WriteEnable && !full_pre) mq.push_back(WriteData);
      if (WriteEnable && full_pre) m_ovf = 1;
      else if (ClearOverflow) m_ovf = 0;
    end
  end

  function automatic int exp_tx();
    int k;
    if (!m_active) return 1;
    k = m_t / CPB;
    if (k == 0) return 0;
    if (k <= 8) return int'(m_byte[k-1]);
    return 1;
  endfunction

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check_output("model_tx", int'(Tx), exp_tx());
      check_output("model_busy", int'(Busy), int'(m_active));
      check_output("model_count", int'(Count), mq.size());
      check_output("model_full", int'(Full), int'(mq.size() == DEPTH));
      check_output("model_empty", int'(Empty), int'(mq.size() == 0));
      check_output("model_overflow", int'(Overflow), int'(m_ovf));
      if (Busy) busy_cycles++;
    end
  end

  // Independent line decoder: samples the middle of each bit of the DUT's Tx.
  logic [7:0] rx_q[$];
  logic [7:0] rx_byte = 8'h00;
  bit         rx_busy = 0;
  int         rx_cnt = 0;
  int         rx_idx;

  always @(negedge clk or negedge reset) begin
    if (!reset) begin
      rx_busy = 0;
      rx_cnt = 0;
    end else if (!rx_busy) begin
      if (Tx == 1'b0) begin
        rx_busy = 1;
        rx_cnt = 0;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt >= CPB + CPB/2 && rx_cnt < 9*CPB && ((rx_cnt - CPB/2) % CPB) == 0) begin
        rx_idx = (rx_cnt - CPB/2) / CPB - 1;
        rx_byte[rx_idx] = Tx;
      end
      if (rx_cnt == 9*CPB + CPB/2) begin
        rx_q.push_back(rx_byte);
        rx_busy = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic apply_stimulus(input logic [7:0] b);
    WriteEnable = 1'b1;
    WriteData = b;
    tick();
    WriteEnable = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((Busy || !Empty) && n < 1000) begin
      tick();
      n++;
    end
    check_output(name, int'(n < 1000), 1);
    repeat (3) tick();
  endtask

  task automatic check_rx(input string name, input logic [7:0] first, input int num);
    check_output({name, "_count"}, rx_q.size(), num);
    for (int i = 0; i < num && i < rx_q.size(); i++) begin
      check_output({name, "_byte"}, int'(rx_q[i]), int'(first) + i);
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [9:0] pat_a5;
    int rate;
    pat_a5 = 10'b1101001010;
    reset = 1'b0;
    WriteEnable = 1'b0;
    WriteData = 8'h00;
    ClearOverflow = 1'b0;
    repeat (3) tick();
    reset = 1'b1;

    check_output("reset_tx", int'(Tx), 1);
    check_output("reset_empty", int'(Empty), 1);
    check_output("reset_count", int'(Count), 0);
    check_output("reset_busy", int'(Busy), 0);
    check_output("reset_overflow", int'(Overflow), 0);
    cmp_en = 1;

    busy_cycles = 0;
    apply_stimulus(8'hA5);
    for (int i = 0; i < 40; i++) begin
      tick();
      check_output("a5_tx", int'(Tx), int'(pat_a5[i/4]));
      check_output("a5_busy", int'(Busy), 1);
    end
    tick();
    check_output("a5_idle_tx", int'(Tx), 1);
    check_output("a5_idle_busy", int'(Busy), 0);
    check_output("a5_busy_cycles", busy_cycles, 40);
    check_rx("a5_rx", 8'hA5, 1);

    rx_q.delete();
    busy_cycles = 0;
    for (int i = 1; i <= 3; i++) begin
      WriteEnable = 1'b1;
      WriteData = 8'(i);
      tick();
    end
    WriteEnable = 1'b0;
    wait_drain("b2b_drain");
    check_output("b2b_busy_cycles", busy_cycles, 120);
    check_rx("b2b_rx", 8'h01, 3);

    rx_q.delete();
    for (int i = 0; i < 6; i++) begin
      WriteEnable = 1'b1;
      WriteData = 8'h10 + 8'(i);
      tick();
    end
    check_output("burst_full", int'(Full), 1);
    check_output("burst_count", int'(Count), 4);
    check_output("burst_overflow", int'(Overflow), 1);
    WriteData = 8'h99;
    ClearOverflow = 1'b1;
    tick();
    check_output("ovf_set_beats_clear", int'(Overflow), 1);
    WriteEnable = 1'b0;
    tick();
    check_output("ovf_cleared", int'(Overflow), 0);
    ClearOverflow = 1'b0;
    wait_drain("burst_drain");
    check_rx("burst_rx", 8'h10, 5);

    rx_q.delete();
    apply_stimulus(8'h3C);
    apply_stimulus(8'h7E);
    repeat (16) tick();
    #1 reset = 1'b0;
    #1;
    check_output("abort_tx", int'(Tx), 1);
    check_output("abort_empty", int'(Empty), 1);
    check_output("abort_count", int'(Count), 0);
    check_output("abort_busy", int'(Busy), 0);
    repeat (2) tick();
    reset = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      check_output("post_reset_tx", int'(Tx), 1);
    end
    check_output("post_reset_rx", rx_q.size(), 0);

    rx_q.delete();
    sent_q.delete();
    for (int ph = 0; ph < 3; ph++) begin
      rate = (ph == 0) ? 2 : ((ph == 1) ? 30 : 90);
      for (int i = 0; i < 1000; i++) begin
        WriteEnable = ($urandom_range(0, rate - 1) == 0);
        WriteData = 8'($urandom);
        ClearOverflow = ($urandom_range(0, 19) == 0);
        tick();
      end
    end
    WriteEnable = 1'b0;
    ClearOverflow = 1'b0;
    wait_drain("random_drain");
    check_output("random_frames", rx_q.size(), sent_q.size());
    for (int i = 0; i < rx_q.size() && i < sent_q.size(); i++) begin
      check_output("random_byte", int'(rx_q[i]), int'(sent_q[i]));
    end

    cmp_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
